// File: rtl/btb_pkg.sv
// Shared types and counter helpers for the branch target buffer.
// Entry fields are sized for the widest supported PC and counter; narrower instances zero-extend.
package btb_pkg;

   localparam int unsigned ADDR_MAX  = 64;
   localparam int unsigned TAG_W     = ADDR_MAX - 2;
   localparam int unsigned CTR_MAX_W = 4;
   localparam int unsigned B_H_DEF   = 2;

   typedef logic [CTR_MAX_W-1:0] ctr_t;

   typedef struct packed {
      logic                valid;
      logic [TAG_W-1:0]    tag;
      logic [ADDR_MAX-1:0] target;
      ctr_t                ctr;
   } btb_entry_t;

   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_JUMP,
      UPD_TAKEN,
      UPD_NTAKEN
   } upd_kind_e;

   function automatic ctr_t ctr_max(input int unsigned bh);
      return ctr_t'((32'd1 << bh) - 32'd1);
   endfunction

   function automatic ctr_t ctr_thr(input int unsigned bh);
      return ctr_t'(32'd1 << (bh - 32'd1));
   endfunction

   function automatic ctr_t ctr_inc(input ctr_t c, input int unsigned bh);
      return (c >= ctr_max(bh)) ? ctr_max(bh) : c + ctr_t'(1);
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == ctr_t'(0)) ? ctr_t'(0) : c - ctr_t'(1);
   endfunction

   localparam ctr_t T = ctr_thr(B_H_DEF);
   localparam ctr_t M = ctr_max(B_H_DEF);

endpackage

// File: rtl/btb_match.sv
// Fully associative tag match over an entry array; reports hit and the lowest matching index.
module btb_match
   import btb_pkg::*;
#(
   parameter int unsigned B_N   = 8,
   parameter int unsigned IDX_W = $clog2(B_N)
) (
   input  btb_entry_t [B_N-1:0] entries,
   input  logic [TAG_W-1:0]     tag,
   output logic                 hit,
   output logic [IDX_W-1:0]     idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int j = 0; j < B_N; j++) begin
         if (!hit && entries[j].valid && (entries[j].tag == tag)) begin
            hit = 1'b1;
            idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Fully associative BTB with saturating direction counters, one lookup port and
// LANES in-order update ports applied sequentially within a cycle.
module btb_predictor
   import btb_pkg::*;
#(
   parameter int unsigned B_N    = 8,
   parameter int unsigned B_H    = 2,
   parameter int unsigned LANES  = 2,
   parameter int unsigned ADDR_W = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enableE,
   input  logic                      StallE,
   input  logic                      flush,
   input  logic [ADDR_W-1:0]         lookup_pc,
   output logic                      pred_hit,
   output logic                      pred_taken,
   output logic [ADDR_W-1:0]         pred_target,
   input  logic [LANES-1:0]          upd_valid,
   input  logic [LANES*ADDR_W-1:0]   upd_pc,
   input  logic [LANES*ADDR_W-1:0]   upd_target,
   input  logic [LANES-1:0]          upd_taken,
   input  logic [LANES-1:0]          upd_jump,
   output logic [$clog2(B_N+1)-1:0]  occupancy,
   output logic [31:0]               evict_cnt
);

   localparam int unsigned IDX_W = $clog2(B_N);
   localparam int unsigned OCC_W = $clog2(B_N + 1);
   localparam ctr_t        ctrThr = ctr_thr(B_H);
   localparam ctr_t        ctrMax = ctr_max(B_H);

   btb_entry_t [B_N-1:0] tbl, tblNxt;
   logic [IDX_W-1:0]     rrPtr, rrPtrNxt;
   logic [31:0]          evictNxt;
   logic [OCC_W-1:0]     occNxt;

   // Lookup sees registered state only
   logic             lkHit;
   logic [IDX_W-1:0] lkIdx;
   logic             unusedLookupLsb;

   assign unusedLookupLsb = ^lookup_pc[1:0];

   btb_match #(.B_N(B_N), .IDX_W(IDX_W)) uLookup (
      .entries (tbl),
      .tag     (TAG_W'(lookup_pc[ADDR_W-1:2])),
      .hit     (lkHit),
      .idx     (lkIdx)
   );

   assign pred_hit    = lkHit;
   assign pred_taken  = lkHit && (tbl[lkIdx].ctr >= ctrThr);
   assign pred_target = lkHit ? tbl[lkIdx].target[ADDR_W-1:0] : '0;

   // One stage per lane; each stage starts from the previous lane's result
   for (genvar i = 0; i < LANES; i++) begin : gLane
      btb_entry_t [B_N-1:0] curTbl, nxtTbl;
      logic [IDX_W-1:0]     curRr, nxtRr, hitIdx, freeIdx, allocIdx;
      logic [31:0]          curEv, nxtEv;
      logic                 hit, freeFound;
      logic [TAG_W-1:0]     updTag;
      logic [ADDR_MAX-1:0]  updTgt;
      upd_kind_e            kind;
      logic                 unusedPcLsb;

      if (i == 0) begin : gFirst
         assign curTbl = tbl;
         assign curRr  = rrPtr;
         assign curEv  = evict_cnt;
      end else begin : gChain
         assign curTbl = gLane[i-1].nxtTbl;
         assign curRr  = gLane[i-1].nxtRr;
         assign curEv  = gLane[i-1].nxtEv;
      end

      assign updTag      = TAG_W'(upd_pc[i*ADDR_W+2 +: ADDR_W-2]);
      assign updTgt      = ADDR_MAX'(upd_target[i*ADDR_W +: ADDR_W]);
      assign unusedPcLsb = ^upd_pc[i*ADDR_W +: 2];

      btb_match #(.B_N(B_N), .IDX_W(IDX_W)) uMatch (
         .entries (curTbl),
         .tag     (updTag),
         .hit     (hit),
         .idx     (hitIdx)
      );

      always_comb begin
         kind = UPD_NONE;
         if (upd_valid[i]) begin
            if (upd_jump[i])       kind = UPD_JUMP;
            else if (upd_taken[i]) kind = UPD_TAKEN;
            else                   kind = UPD_NTAKEN;
         end
      end

      // Lowest-index free slot, falling back to the round-robin victim
      always_comb begin
         freeFound = 1'b0;
         freeIdx   = '0;
         for (int j = 0; j < B_N; j++) begin
            if (!freeFound && !curTbl[j].valid) begin
               freeFound = 1'b1;
               freeIdx   = IDX_W'(j);
            end
         end
         allocIdx = freeFound ? freeIdx : curRr;
      end

      always_comb begin
         nxtTbl = curTbl;
         nxtRr  = curRr;
         nxtEv  = curEv;
         unique case (kind)
            UPD_JUMP, UPD_TAKEN: begin
               if (hit) begin
                  if (kind == UPD_JUMP) begin
                     nxtTbl[hitIdx].ctr    = ctrMax;
                     nxtTbl[hitIdx].target = updTgt;
                  end else if (curTbl[hitIdx].target == updTgt) begin
                     nxtTbl[hitIdx].ctr = ctr_inc(curTbl[hitIdx].ctr, B_H);
                  end else begin
                     nxtTbl[hitIdx].target = updTgt;
                     nxtTbl[hitIdx].ctr    = ctrThr;
                  end
               end else begin
                  nxtTbl[allocIdx].valid  = 1'b1;
                  nxtTbl[allocIdx].tag    = updTag;
                  nxtTbl[allocIdx].target = updTgt;
                  nxtTbl[allocIdx].ctr    = (kind == UPD_JUMP) ? ctrMax : ctrThr;
                  if (!freeFound) begin
                     nxtRr = (curRr == IDX_W'(B_N - 1)) ? '0 : curRr + IDX_W'(1);
                     nxtEv = (curEv == 32'hFFFF_FFFF) ? curEv : curEv + 32'd1;
                  end
               end
            end
            UPD_NTAKEN: begin
               if (hit) begin
                  nxtTbl[hitIdx].ctr = ctr_dec(curTbl[hitIdx].ctr);
                  if (ctr_dec(curTbl[hitIdx].ctr) == ctr_t'(0)) begin
                     nxtTbl[hitIdx].valid = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Flush wins over updates; stall or disable holds the table
   always_comb begin
      tblNxt   = tbl;
      rrPtrNxt = rrPtr;
      evictNxt = evict_cnt;
      if (flush) begin
         for (int j = 0; j < B_N; j++) begin
            tblNxt[j].valid = 1'b0;
         end
      end else if (enableE && !StallE) begin
         tblNxt   = gLane[LANES-1].nxtTbl;
         rrPtrNxt = gLane[LANES-1].nxtRr;
         evictNxt = gLane[LANES-1].nxtEv;
      end
   end

   always_comb begin
      occNxt = '0;
      for (int j = 0; j < B_N; j++) begin
         occNxt = occNxt + OCC_W'(tblNxt[j].valid);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl       <= '0;
         rrPtr     <= '0;
         evict_cnt <= '0;
         occupancy <= '0;
      end else begin
         tbl       <= tblNxt;
         rrPtr     <= rrPtrNxt;
         evict_cnt <= evictNxt;
         occupancy <= occNxt;
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor with B_N=4, B_H=2, LANES=2.
module tb_btb_predictor;

   localparam int unsigned AW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enableE, StallE, flush;
   logic [AW-1:0] lookup_pc;
   logic          pred_hit, pred_taken;
   logic [AW-1:0] pred_target;
   logic [1:0]    upd_valid, upd_taken, upd_jump;
   logic [2*AW-1:0] upd_pc, upd_target;
   logic [2:0]    occupancy;
   logic [31:0]   evict_cnt;

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   btb_predictor #(.B_N(4), .B_H(2), .LANES(2), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enableE     (enableE),
      .StallE      (StallE),
      .flush       (flush),
      .lookup_pc   (lookup_pc),
      .pred_hit    (pred_hit),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken),
      .upd_jump    (upd_jump),
      .occupancy   (occupancy),
      .evict_cnt   (evict_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nTests++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clrLanes();
      upd_valid  = '0;
      upd_taken  = '0;
      upd_jump   = '0;
      upd_pc     = '0;
      upd_target = '0;
   endtask

   task automatic setLane(input int ln, input logic [63:0] pc, input logic [63:0] tgt,
                          input logic tk, input logic jmp);
      upd_valid[ln]          = 1'b1;
      upd_pc[ln*AW +: AW]     = pc;
      upd_target[ln*AW +: AW] = tgt;
      upd_taken[ln]          = tk;
      upd_jump[ln]           = jmp;
   endtask

   // Apply the staged lane inputs at one edge, then clear them
   task automatic step();
      @(posedge clk);
      #1;
      clrLanes();
   endtask

   task automatic look(input logic [63:0] pc, input string tag, input logic hit,
                       input logic tk, input logic [63:0] tgt);
      lookup_pc = pc;
      #1;
      chk({tag, ".hit"}, 64'(pred_hit), 64'(hit));
      chk({tag, ".taken"}, 64'(pred_taken), 64'(tk));
      chk({tag, ".target"}, pred_target, tgt);
   endtask

   initial begin
      rst_n = 1'b0; enableE = 1'b0; StallE = 1'b0; flush = 1'b0;
      lookup_pc = 64'h1000;
      clrLanes();
      #12 rst_n = 1'b1;
      #1;
      look(64'h1000, "rst", 1'b0, 1'b0, 64'h0);
      chk("rst.occ", 64'(occupancy), 64'd0);
      chk("rst.evict", 64'(evict_cnt), 64'd0);
      enableE = 1'b1;

      // Counter walk on a single entry: alloc 2, sat 3, then down to invalid
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0); step();
      look(64'h1000, "alloc", 1'b1, 1'b1, 64'h2000);
      chk("alloc.occ", 64'(occupancy), 64'd1);
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0); step();
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0); step();
      setLane(0, 64'h1000, 64'h2000, 1'b0, 1'b0); step();
      look(64'h1000, "sat_nt1", 1'b1, 1'b1, 64'h2000);
      setLane(0, 64'h1000, 64'h2000, 1'b0, 1'b0); step();
      look(64'h1000, "sat_nt2", 1'b1, 1'b0, 64'h2000);
      setLane(0, 64'h1000, 64'h2000, 1'b0, 1'b0); step();
      look(64'h1000, "inval", 1'b0, 1'b0, 64'h0);
      chk("inval.occ", 64'(occupancy), 64'd0);

      // Two lanes allocate in one cycle
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0);
      setLane(1, 64'h1100, 64'h3000, 1'b1, 1'b0); step();
      chk("dual.occ", 64'(occupancy), 64'd2);
      look(64'h1000, "dual0", 1'b1, 1'b1, 64'h2000);
      look(64'h1100, "dual1", 1'b1, 1'b1, 64'h3000);

      // Fill, then round-robin eviction of entries 0 and 1
      setLane(0, 64'h1200, 64'h4000, 1'b1, 1'b0);
      setLane(1, 64'h1300, 64'h4100, 1'b1, 1'b0); step();
      chk("full.occ", 64'(occupancy), 64'd4);
      chk("full.evict", 64'(evict_cnt), 64'd0);
      setLane(0, 64'h5000, 64'h7000, 1'b1, 1'b0); step();
      chk("ev1.evict", 64'(evict_cnt), 64'd1);
      chk("ev1.occ", 64'(occupancy), 64'd4);
      look(64'h1000, "ev1.old", 1'b0, 1'b0, 64'h0);
      look(64'h5000, "ev1.new", 1'b1, 1'b1, 64'h7000);
      look(64'h1100, "ev1.keep", 1'b1, 1'b1, 64'h3000);
      setLane(0, 64'h6000, 64'h7100, 1'b1, 1'b0); step();
      chk("ev2.evict", 64'(evict_cnt), 64'd2);
      look(64'h1100, "ev2.old", 1'b0, 1'b0, 64'h0);
      look(64'h1200, "ev2.keep", 1'b1, 1'b1, 64'h4000);

      // Flush beats a same-cycle update and keeps evict_cnt
      flush = 1'b1;
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0); step();
      flush = 1'b0;
      chk("flush.occ", 64'(occupancy), 64'd0);
      chk("flush.evict", 64'(evict_cnt), 64'd2);
      look(64'h1000, "flush", 1'b0, 1'b0, 64'h0);

      // Lane 1 sees lane 0's increment: 2 -> 3 -> 2, then one NT leaves 1
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0); step();
      setLane(0, 64'h1000, 64'h2000, 1'b1, 1'b0);
      setLane(1, 64'h1000, 64'h2000, 1'b0, 1'b0); step();
      look(64'h1000, "seq", 1'b1, 1'b1, 64'h2000);
      chk("seq.occ", 64'(occupancy), 64'd1);
      setLane(0, 64'h1000, 64'h2000, 1'b0, 1'b0); step();
      look(64'h1000, "seq.nt", 1'b1, 1'b0, 64'h2000);

      // Taken with a new target resets ctr to T
      setLane(0, 64'h1000, 64'hA000, 1'b1, 1'b0); step();
      look(64'h1000, "retgt", 1'b1, 1'b1, 64'hA000);
      setLane(0, 64'h1000, 64'hA000, 1'b0, 1'b0); step();
      look(64'h1000, "retgt.nt", 1'b1, 1'b0, 64'hA000);

      // Jump hit: ctr to max, target replaced; two NT leave ctr 1
      setLane(0, 64'h1000, 64'h9000, 1'b0, 1'b1); step();
      setLane(0, 64'h1000, 64'h9000, 1'b0, 1'b0); step();
      look(64'h1000, "jmp.nt1", 1'b1, 1'b1, 64'h9000);
      setLane(0, 64'h1000, 64'h9000, 1'b0, 1'b0); step();
      look(64'h1000, "jmp.nt2", 1'b1, 1'b0, 64'h9000);

      // Stalled or disabled updates leave the table alone
      StallE = 1'b1;
      setLane(0, 64'h3000, 64'h3400, 1'b1, 1'b0); step();
      StallE = 1'b0;
      chk("stall.occ", 64'(occupancy), 64'd1);
      look(64'h3000, "stall", 1'b0, 1'b0, 64'h0);
      enableE = 1'b0;
      setLane(0, 64'h3000, 64'h3400, 1'b1, 1'b0); step();
      enableE = 1'b1;
      chk("dis.occ", 64'(occupancy), 64'd1);

      // Jump miss allocates at max: one NT still predicts taken
      setLane(0, 64'h3000, 64'h3400, 1'b0, 1'b1); step();
      chk("jalloc.occ", 64'(occupancy), 64'd2);
      setLane(0, 64'h3000, 64'h3400, 1'b0, 1'b0); step();
      look(64'h3000, "jalloc.nt", 1'b1, 1'b1, 64'h3400);

      // Asynchronous reset mid-cycle clears lookup immediately
      #2 rst_n = 1'b0;
      #1;
      look(64'h3000, "arst", 1'b0, 1'b0, 64'h0);
      chk("arst.occ", 64'(occupancy), 64'd0);
      chk("arst.evict", 64'(evict_cnt), 64'd0);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
